// File: rtl/regfile_pkg.sv
// Shared constants and types for the scoreboarded register file.
package regfile_pkg;
    localparam int A_WIDTH_DEF = 5;
    localparam int D_WIDTH_DEF = 32;
    localparam int REG_ZERO    = 0;
    localparam int REG_A0      = 10;

    typedef logic [A_WIDTH_DEF-1:0] reg_addr_t;
endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard: a bit per register set on issue, cleared on write-back,
// plus a registered count of busy registers.
module reg_scoreboard
    import regfile_pkg::*;
#(
    parameter int A_WIDTH = A_WIDTH_DEF,
    parameter int NUM_RD  = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [A_WIDTH-1:0]        wr_addr,
    input  logic                      iss_en,
    input  logic [A_WIDTH-1:0]        iss_addr,
    input  logic [NUM_RD*A_WIDTH-1:0] rd_addr,
    output logic [NUM_RD-1:0]         rd_busy,
    output logic [A_WIDTH:0]          pending
);
    localparam int DEPTH = 2 ** A_WIDTH;
    localparam logic [A_WIDTH:0] PEND_MAX = (A_WIDTH + 1)'(DEPTH - 1);

    logic [DEPTH-1:0] r_busy;
    logic [A_WIDTH:0] r_pending;
    logic [DEPTH-1:0] w_busy_next;
    logic             w_set;
    logic             w_clr;
    logic             w_inc;
    logic             w_dec;

    // Register 0 is hard-wired, so it never participates in tracking.
    assign w_set = iss_en && (iss_addr != A_WIDTH'(REG_ZERO));
    assign w_clr = wr_en && (wr_addr != A_WIDTH'(REG_ZERO));

    // A same-register issue outranks the write-back: the new producer is still in flight.
    assign w_inc = w_set && !r_busy[iss_addr];
    assign w_dec = w_clr && r_busy[wr_addr] && !(w_set && (iss_addr == wr_addr));

    always_comb begin
        w_busy_next = r_busy;
        if (w_clr) begin
            w_busy_next[wr_addr] = 1'b0;
        end
        if (w_set) begin
            w_busy_next[iss_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy    <= '0;
            r_pending <= '0;
        end else begin
            r_busy <= w_busy_next;
            if (w_inc && !w_dec && (r_pending != PEND_MAX)) begin
                r_pending <= r_pending + 1'b1;
            end else if (w_dec && !w_inc && (r_pending != '0)) begin
                r_pending <= r_pending - 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_busy
        logic [A_WIDTH-1:0] w_addr;
        logic               w_wr_hit;
        logic               w_iss_hit;
        assign w_addr    = rd_addr[gi*A_WIDTH +: A_WIDTH];
        assign w_wr_hit  = w_clr && (wr_addr == w_addr);
        assign w_iss_hit = w_set && (iss_addr == w_addr);
        assign rd_busy[gi] = r_busy[w_addr] && !(w_wr_hit && !w_iss_hit);
    end

    assign pending = r_pending;
endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with write-through bypass, a hard-zero x0,
// and a scoreboard that tracks registers awaiting write-back.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int A_WIDTH = A_WIDTH_DEF,
    parameter int D_WIDTH = D_WIDTH_DEF,
    parameter int NUM_RD  = 2,
    parameter int A0_IDX  = REG_A0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_RD*A_WIDTH-1:0] rd_addr,
    output logic [NUM_RD*D_WIDTH-1:0] rd_data,
    output logic [NUM_RD-1:0]         rd_busy,
    input  logic                      wr_en,
    input  logic [A_WIDTH-1:0]        wr_addr,
    input  logic [D_WIDTH-1:0]        wr_data,
    input  logic                      iss_en,
    input  logic [A_WIDTH-1:0]        iss_addr,
    output logic [A_WIDTH:0]          pending,
    output logic [D_WIDTH-1:0]        a0
);
    localparam int DEPTH = 2 ** A_WIDTH;

    logic [D_WIDTH-1:0] r_mem [DEPTH];
    logic               w_wr_ok;

    assign w_wr_ok = wr_en && (wr_addr != A_WIDTH'(REG_ZERO));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_mem[k] <= '0;
            end
        end else if (w_wr_ok) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
        logic [A_WIDTH-1:0] w_addr;
        assign w_addr = rd_addr[gi*A_WIDTH +: A_WIDTH];
        assign rd_data[gi*D_WIDTH +: D_WIDTH] =
            (w_wr_ok && (wr_addr == w_addr))   ? wr_data :
            (w_addr == A_WIDTH'(REG_ZERO))     ? '0      :
                                                 r_mem[w_addr];
    end

    // a0 deliberately skips the bypass so it reflects committed state only.
    assign a0 = r_mem[A_WIDTH'(A0_IDX)];

    reg_scoreboard #(
        .A_WIDTH (A_WIDTH),
        .NUM_RD  (NUM_RD)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .rd_addr  (rd_addr),
        .rd_busy  (rd_busy),
        .pending  (pending)
    );
endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter A_WIDTH, default 5, SHALL set the register address width; depth is 2**A_WIDTH.
REQ-002 Parameter D_WIDTH, default 32, SHALL set the register data width.
REQ-003 Parameter NUM_RD, default 2, SHALL set the number of independent read ports (1..4).
REQ-004 Parameter A0_IDX, default 10, SHALL select the register exported on a0.
REQ-005 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-007 rd_addr  input  NUM_RD*A_WIDTH  SHALL carry the packed read addresses; port i uses slice i.
REQ-008 rd_data  output  NUM_RD*D_WIDTH  SHALL carry the packed read data.
REQ-009 rd_busy  output  NUM_RD  SHALL flag a pending write on each read port's register.
REQ-010 wr_en  input  1  SHALL be the write-back strobe.
REQ-011 wr_addr  input  A_WIDTH  SHALL be the write-back register.
REQ-012 wr_data  input  D_WIDTH  SHALL be the write-back data.
REQ-013 iss_en  input  1  SHALL be the issue strobe that marks a destination pending.
REQ-014 iss_addr  input  A_WIDTH  SHALL be the issued destination register.
REQ-015 pending  output  A_WIDTH+1  SHALL give the count of currently busy registers.
REQ-016 a0  output  D_WIDTH  SHALL present the stored value of register A0_IDX.

Function
REQ-017 Register 0 SHALL always read 0 and SHALL never be busy; writes and issues to it SHALL be ignored.
REQ-018 Reads SHALL be combinational: rd_data[i] = stored value of rd_addr[i], except as REQ-019 overrides.
REQ-019 When wr_en=1 and wr_addr=rd_addr[i]≠0, rd_data[i] SHALL equal wr_data in the same cycle (write-through bypass).
REQ-020 Write SHALL update the array at the rising edge with wr_en=1; latency 0 cycles to read via bypass, 1 cycle via array.
REQ-021 Busy bit for register r SHALL set at the edge where iss_en=1, iss_addr=r, and SHALL clear at the edge where wr_en=1, wr_addr=r.
REQ-022 Simultaneous iss_en and wr_en to the same register SHALL leave busy set and SHALL store wr_data.
REQ-023 rd_busy[i] SHALL reflect the registered busy bit, forced to 0 when a same-cycle write targets that register and no same-cycle issue targets it.
REQ-024 Issue to an already-busy register SHALL keep it busy (no count increment); write to a non-busy register SHALL write data and leave busy clear.
REQ-025 pending SHALL be a registered counter: +1 on a new busy set, -1 on a busy clear, unchanged when both occur on different registers; it SHALL never exceed 2**A_WIDTH-1 nor go below 0.
REQ-026 a0 SHALL be taken from the array (no bypass), updating one cycle after a write to A0_IDX.

Reset
REQ-027 While rst=1 at a rising edge, all registers SHALL clear to 0, all busy bits and pending SHALL clear to 0; wr_en and iss_en SHALL be ignored that cycle.
REQ-028 After reset, a0=0, rd_busy=0, and rd_data=0 for every address with no same-cycle write.
REQ-029 Reset asserted mid-operation SHALL discard all outstanding pending writes.

Structure
REQ-030 Package regfile_pkg SHALL hold default A_WIDTH/D_WIDTH, REG_ZERO=0, REG_A0=10 constants and a reg_addr_t typedef.
REQ-031 Busy tracking and pending counter SHALL live in one sub-module reg_scoreboard; data array and bypass in regfile_sb.

Verification
REQ-032 Reset, then read all 32 addresses on both ports -> rd_data=0, rd_busy=0, pending=0, a0=0.
REQ-033 Write x5=0xDEADBEEF with rd_addr[0]=5 same cycle -> rd_data[0]=0xDEADBEEF that cycle and after; write x0=0x1234 -> reads of x0 return 0.
REQ-034 Issue x7, x8 -> pending=2, rd_busy set on x7; write-back x7=0x55 -> rd_busy clears same cycle, pending=1 next cycle.
REQ-035 Same cycle issue x9 and write x9=0xAA -> x9 busy next cycle, data 0xAA, pending +1.
REQ-036 Write x10=0x42 -> a0=0x42 on the following cycle, not the write cycle.
REQ-037 Issue x3, x4, then rst=1 for one cycle -> pending=0, all busy clear, x3/x4 read 0.
